// File: rtl/dispense_servo_ctrl_pkg.sv
// vend_pkg: shared FSM state type, slot count and default servo timing constants
//   NUM_SLOTS / SLOT_W  : number of dispense slots and width of a slot index
//   DEF_*               : default frame and pulse timing (50 MHz clock, 20 ms frames)
//   lowest_idx()        : index of the lowest set bit of a slot mask (0 if none)
package vend_pkg;
    typedef enum logic [2:0] {IDLE, OPEN, HOLD, CLOSE, DONE} state_t;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W = 2;
    localparam int DEF_PERIOD_CYC = 1000000;
    localparam int DEF_PULSE_CLOSE_CYC = 25000;
    localparam int DEF_PULSE_OPEN_CYC = 125000;
    localparam int DEF_OPEN_FRAMES = 25;
    localparam int DEF_HOLD_FRAMES = 50;
    localparam int DEF_CLOSE_FRAMES = 25;
    function automatic logic [SLOT_W-1:0] lowest_idx(input logic [NUM_SLOTS-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (m[i]) lowest_idx = SLOT_W'(i);
    endfunction
endpackage

// File: rtl/dispense_servo_ctrl_if.sv
// dispense_servo_ctrl_if: request/status bundle between the payment stage and the servo controller
//   good, en_duoji, credit_ok             : requests and gating (master -> slave)
//   servo_pwm, busy, active_slot, done,
//   pending                               : servo drive and status (slave -> master)
interface dispense_servo_ctrl_if;
    import vend_pkg::*;
    logic [NUM_SLOTS-1:0] good;
    logic                 en_duoji;
    logic                 credit_ok;
    logic [NUM_SLOTS-1:0] servo_pwm;
    logic                 busy;
    logic [SLOT_W-1:0]    active_slot;
    logic                 done;
    logic [NUM_SLOTS-1:0] pending;
    modport master(output good, en_duoji, credit_ok, input servo_pwm, busy, active_slot, done, pending);
    modport slave(input good, en_duoji, credit_ok, output servo_pwm, busy, active_slot, done, pending);
endinterface

// File: rtl/dispense_servo_ctrl_servo_pwm_gen.sv
// servo_pwm_gen: free-running servo frame counter shared by all channels
//   clock, clr_n : clock and asynchronous active-low reset
//   frame_end    : high in the last cycle of each frame
//   open_hi      : high while the frame position is inside the open-pulse width
//   close_hi     : high while the frame position is inside the closed-pulse width
module servo_pwm_gen #(
    parameter int PERIOD_CYC = 1000000,
    parameter int PULSE_CLOSE_CYC = 25000,
    parameter int PULSE_OPEN_CYC = 125000
) (
    input  logic clock,
    input  logic clr_n,
    output logic frame_end,
    output logic open_hi,
    output logic close_hi
);
    localparam int W = $clog2(PERIOD_CYC);
    localparam logic [W-1:0] LAST = W'(PERIOD_CYC - 1);
    localparam logic [W-1:0] OPEN_W = W'(PULSE_OPEN_CYC);
    localparam logic [W-1:0] CLOSE_W = W'(PULSE_CLOSE_CYC);
    logic [W-1:0] fcnt;
    always_ff @(posedge clock or negedge clr_n)
        if (!clr_n) fcnt <= '0;
        else fcnt <= frame_end ? '0 : fcnt + 1'b1;
    assign frame_end = fcnt == LAST;
    assign open_hi = fcnt < OPEN_W;
    assign close_hi = fcnt < CLOSE_W;
endmodule

// File: rtl/dispense_servo_ctrl.sv
// dispense_servo_ctrl: queues per-slot purchase edges and runs one servo open/hold/close cycle per request
//   clock, clr_n : clock and asynchronous active-low reset
//   bus          : slave side of dispense_servo_ctrl_if (requests in, PWM and status out)
module dispense_servo_ctrl import vend_pkg::*; #(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int PULSE_CLOSE_CYC = DEF_PULSE_CLOSE_CYC,
    parameter int PULSE_OPEN_CYC = DEF_PULSE_OPEN_CYC,
    parameter int OPEN_FRAMES = DEF_OPEN_FRAMES,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int CLOSE_FRAMES = DEF_CLOSE_FRAMES
) (
    input logic clock,
    input logic clr_n,
    dispense_servo_ctrl_if.slave bus
);
    localparam int MAXF = OPEN_FRAMES > HOLD_FRAMES ? (OPEN_FRAMES > CLOSE_FRAMES ? OPEN_FRAMES : CLOSE_FRAMES)
                                                    : (HOLD_FRAMES > CLOSE_FRAMES ? HOLD_FRAMES : CLOSE_FRAMES);
    localparam int FW = MAXF > 1 ? $clog2(MAXF) : 1;
    state_t state, state_n;
    logic [FW-1:0] frm, frm_n, limit;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [NUM_SLOTS-1:0] good_q, rise, clear, pend;
    logic armed, frame_end, open_hi, close_hi, pwm_hi;
    servo_pwm_gen #(
        .PERIOD_CYC(PERIOD_CYC),
        .PULSE_CLOSE_CYC(PULSE_CLOSE_CYC),
        .PULSE_OPEN_CYC(PULSE_OPEN_CYC)
    ) u_gen (
        .clock(clock),
        .clr_n(clr_n),
        .frame_end(frame_end),
        .open_hi(open_hi),
        .close_hi(close_hi)
    );
    // armed stays low for the first cycle after reset so a level already high is not taken as a purchase
    assign rise = armed ? bus.good & ~good_q : '0;
    always_comb begin
        state_n = state;
        frm_n = frm;
        slot_n = slot;
        clear = '0;
        limit = state == OPEN ? FW'(OPEN_FRAMES - 1) : state == HOLD ? FW'(HOLD_FRAMES - 1) : FW'(CLOSE_FRAMES - 1);
        case (state)
            IDLE:
                if (frame_end && |pend && bus.en_duoji && bus.credit_ok) begin
                    state_n = OPEN;
                    frm_n = '0;
                    slot_n = lowest_idx(pend);
                    clear = NUM_SLOTS'(1) << slot_n;
                end
            OPEN, HOLD, CLOSE:
                if (frame_end) begin
                    if (frm == limit) begin
                        state_n = state == OPEN ? HOLD : state == HOLD ? CLOSE : DONE;
                        frm_n = '0;
                    end else frm_n = frm + 1'b1;
                end
            DONE: begin
                state_n = IDLE;
                slot_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge clr_n)
        if (!clr_n) begin
            state <= IDLE;
            frm <= '0;
            slot <= '0;
            pend <= '0;
            good_q <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            frm <= frm_n;
            slot <= slot_n;
            // a new edge on the slot being started is absorbed; any other edge re-queues its slot
            pend <= (pend | rise) & ~clear;
            good_q <= bus.good;
            armed <= 1'b1;
        end
    assign pwm_hi = (state == OPEN || state == HOLD) ? open_hi : (state == CLOSE && close_hi);
    assign bus.servo_pwm = pwm_hi ? NUM_SLOTS'(1) << slot : '0;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.active_slot = slot;
    assign bus.pending = pend;
endmodule

// File: tb/tb_dispense_servo_ctrl.sv
// tb_dispense_servo_ctrl: scoreboard bench comparing the servo controller against a service-timeline model
module tb_dispense_servo_ctrl;
    import vend_pkg::*;
    localparam int P = 100, PC = 5, PO = 10, OF = 2, HF = 3, CF = 2;
    localparam int SVC = (OF + HF + CF) * P;

    typedef struct {
        int k;
        logic [3:0] pwm;
        logic busy;
        logic [1:0] act;
        logic done;
        logic [3:0] pend;
    } exp_t;
    typedef struct {
        int slot;
        int k;
    } ev_t;

    logic clock = 0;
    logic clr_n = 0;
    always #5 clock = ~clock;

    dispense_servo_ctrl_if bus();
    dispense_servo_ctrl #(
        .PERIOD_CYC(P), .PULSE_CLOSE_CYC(PC), .PULSE_OPEN_CYC(PO),
        .OPEN_FRAMES(OF), .HOLD_FRAMES(HF), .CLOSE_FRAMES(CF)
    ) dut (
        .clock(clock),
        .clr_n(clr_n),
        .bus(bus.slave)
    );

    exp_t cyc_q[$];
    ev_t ev_q[$];
    int n_chk = 0, n_fail = 0;

    // Reference model: a service is a timeline starting at the decision cycle m_s.
    int k = 0, m_s = 0, m_slot = 0;
    logic m_on = 0;
    logic [3:0] m_pend = 0, m_prev = 0;
    logic [3:0] cur_g = 0;
    logic cur_e = 1, cur_c = 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x, input int cyc);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, x);
        end
    endtask

    task automatic push_zero();
        exp_t e;
        e.k = -1; e.pwm = 0; e.busy = 0; e.act = 0; e.done = 0; e.pend = 0;
        cyc_q.push_back(e);
    endtask

    task automatic body();
        exp_t e;
        logic on;
        int rel;
        logic [3:0] rise, clr;
        on = m_on && k <= m_s + SVC + 1;
        e.k = k;
        e.busy = on;
        e.act = on ? 2'(m_slot) : 2'd0;
        e.done = on && k == m_s + SVC + 1;
        e.pend = m_pend;
        e.pwm = 0;
        if (on && k <= m_s + SVC) begin
            rel = k - m_s - 1;
            if ((rel / P < OF + HF) ? (rel % P < PO) : (rel % P < PC)) e.pwm = 4'(1 << m_slot);
        end
        cyc_q.push_back(e);
        bus.good = cur_g;
        bus.en_duoji = cur_e;
        bus.credit_ok = cur_c;
        rise = k >= 1 ? cur_g & ~m_prev : 4'd0;
        clr = 0;
        if (!on && k % P == P - 1 && m_pend != 0 && cur_e && cur_c) begin
            for (int i = 0; i < 4; i++) if (m_pend[i]) begin m_slot = i; break; end
            clr = 4'(1 << m_slot);
            m_s = k;
            m_on = 1;
            ev_q.push_back('{m_slot, k + SVC + 1});
        end
        m_pend = (m_pend | rise) & ~clr;
        m_prev = cur_g;
        k++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        body();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clock);
        #1;
        clr_n = 0;
        ev_q.delete();
        m_pend = 0;
        m_on = 0;
        push_zero();
        repeat (n) begin
            @(posedge clock);
            #1;
            push_zero();
        end
        @(posedge clock);
        #1;
        clr_n = 1;
        k = 0;
        body();
    endtask

    // Monitor: every cycle compares the outputs; each done pulse retires one queued service.
    always @(negedge clock) begin
        if (cyc_q.size() > 0) begin
            exp_t e;
            ev_t v;
            e = cyc_q.pop_front();
            chk("servo_pwm", 32'(bus.servo_pwm), 32'(e.pwm), e.k);
            chk("busy", 32'(bus.busy), 32'(e.busy), e.k);
            chk("active_slot", 32'(bus.active_slot), 32'(e.act), e.k);
            chk("done", 32'(bus.done), 32'(e.done), e.k);
            chk("pending", 32'(bus.pending), 32'(e.pend), e.k);
            if (bus.done === 1'b1) begin
                if (ev_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_unexpected at cycle %0d: got done=1 expected no service end", e.k);
                end else begin
                    v = ev_q.pop_front();
                    chk("done_slot", 32'(bus.active_slot), 32'(v.slot), e.k);
                    chk("done_cycle", 32'(e.k), 32'(v.k), e.k);
                end
            end
        end
    end

    initial begin
        bus.good = 0;
        bus.en_duoji = 1;
        bus.credit_ok = 1;
        reset_pulse(3);
        // single buy on slot 2
        run(5);
        cur_g = 4'b0100; tick();
        cur_g = 0; run(900);
        // priority: slots 3 and 1 together
        cur_g = 4'b1010; tick();
        cur_g = 0; run(1700);
        // gating by credit_ok
        cur_c = 0;
        cur_g = 4'b0001; tick();
        cur_g = 0; run(300);
        cur_c = 1; run(900);
        // re-request slot 0 while it is holding open
        cur_g = 4'b0001; tick();
        cur_g = 0; run(350);
        cur_g = 4'b0001; tick();
        cur_g = 0; run(3);
        cur_g = 4'b0001; tick();
        cur_g = 0; run(1800);
        // random traffic, then drain
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) cur_g[$urandom_range(3)] = ~cur_g[$urandom_range(3)];
            if ($urandom_range(299) == 0) cur_e = ~cur_e;
            if ($urandom_range(299) == 0) cur_c = ~cur_c;
            tick();
        end
        cur_g = 0; cur_e = 1; cur_c = 1;
        run(4000);
        // reset in the second frame of OPEN while the request level stays high
        cur_g = 4'b0010; tick();
        for (int i = 0; i < 400 && !(m_on && k > m_s && k <= m_s + SVC && (k - m_s - 1) / P == 1); i++) tick();
        chk("reached_open_frame1", 32'(m_on && k > m_s && (k - m_s - 1) / P == 1), 32'd1, k);
        reset_pulse(2);
        run(400);
        cur_g = 0;
        run(2);
        @(negedge clock);
        #1;
        chk("services_all_done", 32'(ev_q.size()), 32'd0, k);
        chk("monitor_drained", 32'(cyc_q.size()), 32'd0, k);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
